// File: rtl/pipe_mult_acc.sv
// Pipelined signed multiply-accumulate with rounding shift and saturate/wrap output.
// Latency: STAGES clocks pipe_in -> pipe_out; one sample per clock, bubbles allowed.
// Backpressure: none; each stage is clock-enabled by the valid bit travelling with it.
module pipe_mult_acc #(
  parameter int A_WIDTH   = 25,
  parameter int B_WIDTH   = 18,
  parameter int STAGES    = 3,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 43,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pipe_in,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic                        acc_en,
  input  logic                        acc_clr,
  output logic                        pipe_out,
  output logic signed [OUT_WIDTH-1:0] p,
  output logic                        ovf
);

  localparam int PW   = A_WIDTH + B_WIDTH;
  localparam int LAST = STAGES - 2;
  localparam logic signed [ACC_WIDTH:0]   RND   = ((ACC_WIDTH+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [OUT_WIDTH-1:0] MAX_P = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_P = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [STAGES-1:0]          pipe;
  logic signed [A_WIDTH-1:0]  a_r;
  logic signed [B_WIDTH-1:0]  b_r;
  logic                       en_r;
  logic                       clr_r;
  logic signed [PW-1:0]       mult;
  // Index k holds the product/control registered by stage k (1..STAGES-2).
  logic signed [PW-1:0]       prod_q [1:LAST];
  logic                       en_q   [1:LAST];
  logic                       clr_q  [1:LAST];
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH:0]   rnd_sum;
  logic signed [ACC_WIDTH:0]   r;
  logic                        r_fits;
  logic signed [OUT_WIDTH-1:0] p_next;

  assign pipe_out = pipe[STAGES-1];
  assign mult     = PW'(a_r) * PW'(b_r);

  always_comb begin
    acc_base = (en_q[LAST] && !clr_q[LAST]) ? acc : '0;
    acc_next = acc_base + ACC_WIDTH'(prod_q[LAST]);
    // One extra bit keeps the rounding add from overflowing.
    rnd_sum  = (ACC_WIDTH+1)'(acc_next) + RND;
    r        = rnd_sum >>> OUT_SHIFT;
    r_fits   = (&r[ACC_WIDTH:OUT_WIDTH-1]) || !(|r[ACC_WIDTH:OUT_WIDTH-1]);
    if (r_fits || SATURATE == 0) begin
      p_next = r[OUT_WIDTH-1:0];
    end else begin
      p_next = r[ACC_WIDTH] ? MIN_P : MAX_P;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      en_r  <= 1'b0;
      clr_r <= 1'b0;
      for (int k = 1; k <= LAST; k++) begin
        prod_q[k] <= '0;
        en_q[k]   <= 1'b0;
        clr_q[k]  <= 1'b0;
      end
      acc <= '0;
      p   <= '0;
      ovf <= 1'b0;
    end else begin
      pipe <= {pipe[STAGES-2:0], pipe_in};
      if (pipe_in) begin
        a_r   <= a;
        b_r   <= b;
        en_r  <= acc_en;
        clr_r <= acc_clr;
      end
      if (pipe[0]) begin
        prod_q[1] <= mult;
        en_q[1]   <= en_r;
        clr_q[1]  <= clr_r;
      end
      for (int k = 2; k <= LAST; k++) begin
        if (pipe[k-1]) begin
          prod_q[k] <= prod_q[k-1];
          en_q[k]   <= en_q[k-1];
          clr_q[k]  <= clr_q[k-1];
        end
      end
      if (pipe[LAST]) begin
        acc <= acc_next;
        p   <= p_next;
        ovf <= !r_fits;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mult_acc.sv
// Directed bench for pipe_mult_acc: four instances cover default, deep pipe,
// and 16-bit rounded output in saturate and wrap modes.
module tb_pipe_mult_acc;

  logic clk;
  logic reset;
  logic pipe_in;
  logic signed [24:0] a;
  logic signed [17:0] b;
  logic acc_en;
  logic acc_clr;

  logic po0, po1, po2, po3;
  logic ovf0, ovf1, ovf2, ovf3;
  logic signed [42:0] p0, p1;
  logic signed [15:0] p2, p3;

  int checks = 0;
  int failures = 0;

  pipe_mult_acc dut0 (
    .clk(clk), .reset(reset), .pipe_in(pipe_in), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .pipe_out(po0), .p(p0), .ovf(ovf0)
  );
  pipe_mult_acc #(.STAGES(5)) dut1 (
    .clk(clk), .reset(reset), .pipe_in(pipe_in), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .pipe_out(po1), .p(p1), .ovf(ovf1)
  );
  pipe_mult_acc #(.OUT_WIDTH(16), .OUT_SHIFT(4)) dut2 (
    .clk(clk), .reset(reset), .pipe_in(pipe_in), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .pipe_out(po2), .p(p2), .ovf(ovf2)
  );
  pipe_mult_acc #(.OUT_WIDTH(16), .OUT_SHIFT(4), .SATURATE(0)) dut3 (
    .clk(clk), .reset(reset), .pipe_in(pipe_in), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .pipe_out(po3), .p(p3), .ovf(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input set and advance to the next falling edge.
  task automatic send(input logic pi, input logic signed [24:0] av,
                      input logic signed [17:0] bv, input logic en, input logic clr);
    pipe_in = pi;
    a       = av;
    b       = bv;
    acc_en  = en;
    acc_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    send(1'b0, 25'sd0, 18'sd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pipe_in = 1'b1;
      a       = 25'($urandom);
      b       = 18'($urandom);
      acc_en  = 1'($urandom);
      acc_clr = 1'($urandom);
      @(negedge clk);
      checks++; if (po0 !== 1'b0) begin failures++; $display("FAIL rst_pipe_out got %b exp 0", po0); end
      checks++; if (p0 !== 43'sd0) begin failures++; $display("FAIL rst_p got %0d exp 0", p0); end
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL rst_ovf got %b exp 0", ovf0); end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (po0 !== 1'b0 || po1 !== 1'b0) begin failures++; $display("FAIL post_rst_pipe_out got %b/%b exp 0/0", po0, po1); end
      checks++; if (p0 !== 43'sd0 || ovf0 !== 1'b0) begin failures++; $display("FAIL post_rst_p got %0d ovf %b exp 0 ovf 0", p0, ovf0); end
    end
  endtask

  task automatic test_latency();
    send(1'b1, -25'sd3, 18'sd7, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      checks++; if (po0 !== (k == 3)) begin failures++; $display("FAIL lat3_pipe_out k=%0d got %b exp %b", k, po0, (k == 3)); end
      checks++; if (po1 !== (k == 5)) begin failures++; $display("FAIL lat5_pipe_out k=%0d got %b exp %b", k, po1, (k == 5)); end
      if (k >= 3) begin
        checks++; if (p0 !== -43'sd21) begin failures++; $display("FAIL lat3_p k=%0d got %0d exp -21", k, p0); end
      end
      if (k >= 5) begin
        checks++; if (p1 !== -43'sd21) begin failures++; $display("FAIL lat5_p k=%0d got %0d exp -21", k, p1); end
      end
      if (k == 3) begin
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL lat3_ovf got %b exp 0", ovf0); end
      end
      idle();
    end
  endtask

  task automatic test_extremes();
    logic signed [42:0] e1;
    logic signed [42:0] e2;
    e1 = 43'h20000000000;
    e2 = 43'h60000020000;
    send(1'b1, 25'h1000000, 18'h20000, 1'b0, 1'b0);
    send(1'b1, 25'h0FFFFFF, 18'h20000, 1'b0, 1'b0);
    idle();
    checks++; if (po0 !== 1'b1 || p0 !== e1) begin failures++; $display("FAIL ext_max got %0d valid %b exp %0d valid 1", p0, po0, e1); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ext_max_ovf got %b exp 0", ovf0); end
    idle();
    checks++; if (po0 !== 1'b1 || p0 !== e2) begin failures++; $display("FAIL ext_neg got %0d valid %b exp %0d valid 1", p0, po0, e2); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ext_neg_ovf got %b exp 0", ovf0); end
  endtask

  task automatic test_accumulate();
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b1);
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b0);
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b0);
    checks++; if (p0 !== 43'sd1000000) begin failures++; $display("FAIL acc_1 got %0d exp 1000000", p0); end
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b0);
    checks++; if (p0 !== 43'sd2000000) begin failures++; $display("FAIL acc_2 got %0d exp 2000000", p0); end
    idle();
    checks++; if (p0 !== 43'sd3000000) begin failures++; $display("FAIL acc_3 got %0d exp 3000000", p0); end
    idle();
    checks++; if (p0 !== 43'sd4000000) begin failures++; $display("FAIL acc_4 got %0d exp 4000000", p0); end

    // Same sum with a two-clock bubble after the second sample.
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b1);
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b0);
    idle();
    checks++; if (p0 !== 43'sd1000000) begin failures++; $display("FAIL bub_1 got %0d exp 1000000", p0); end
    idle();
    checks++; if (p0 !== 43'sd2000000) begin failures++; $display("FAIL bub_2 got %0d exp 2000000", p0); end
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b0);
    checks++; if (po0 !== 1'b0 || p0 !== 43'sd2000000) begin failures++; $display("FAIL bub_hold got %0d valid %b exp 2000000 valid 0", p0, po0); end
    send(1'b1, 25'sd1000, 18'sd1000, 1'b1, 1'b0);
    checks++; if (po0 !== 1'b0) begin failures++; $display("FAIL bub_gap got %b exp 0", po0); end
    idle();
    checks++; if (p0 !== 43'sd3000000) begin failures++; $display("FAIL bub_3 got %0d exp 3000000", p0); end
    send(1'b1, 25'sd7, 18'sd9, 1'b1, 1'b1);
    checks++; if (p0 !== 43'sd4000000) begin failures++; $display("FAIL bub_4 got %0d exp 4000000", p0); end
    idle();
    idle();
    checks++; if (po0 !== 1'b1 || p0 !== 43'sd63) begin failures++; $display("FAIL acc_restart got %0d valid %b exp 63 valid 1", p0, po0); end
  endtask

  task automatic test_round_sat();
    send(1'b1, 25'sd3, 18'sd3, 1'b0, 1'b0);
    send(1'b1, -25'sd3, 18'sd3, 1'b0, 1'b0);
    send(1'b1, 25'sd1000, 18'sd1000, 1'b0, 1'b0);
    checks++; if (p2 !== 16'sd1 || ovf2 !== 1'b0) begin failures++; $display("FAIL rnd_pos got %0d ovf %b exp 1 ovf 0", p2, ovf2); end
    checks++; if (p3 !== 16'sd1) begin failures++; $display("FAIL rnd_pos_wrap got %0d exp 1", p3); end
    idle();
    checks++; if (p2 !== -16'sd1 || ovf2 !== 1'b0) begin failures++; $display("FAIL rnd_neg got %0d ovf %b exp -1 ovf 0", p2, ovf2); end
    checks++; if (p3 !== -16'sd1) begin failures++; $display("FAIL rnd_neg_wrap got %0d exp -1", p3); end
    idle();
    checks++; if (p2 !== 16'sd32767 || ovf2 !== 1'b1) begin failures++; $display("FAIL sat_hi got %0d ovf %b exp 32767 ovf 1", p2, ovf2); end
    checks++; if (p3 !== -16'sd3036 || ovf3 !== 1'b1) begin failures++; $display("FAIL wrap_hi got %0d ovf %b exp -3036 ovf 1", p3, ovf3); end
    checks++; if (p0 !== 43'sd1000000 || ovf0 !== 1'b0) begin failures++; $display("FAIL wide_no_ovf got %0d ovf %b exp 1000000 ovf 0", p0, ovf0); end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 25'sd100, 18'sd100, 1'b1, 1'b0);
    send(1'b1, 25'sd100, 18'sd100, 1'b1, 1'b0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checks++; if (p0 !== 43'sd0) begin failures++; $display("FAIL mid_rst_p got %0d exp 0", p0); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (po0 !== 1'b0 || po1 !== 1'b0) begin failures++; $display("FAIL mid_rst_flush k=%0d got %b/%b exp 0/0", k, po0, po1); end
      idle();
    end
    send(1'b1, 25'sd5, 18'sd5, 1'b1, 1'b0);
    idle();
    idle();
    checks++; if (po0 !== 1'b1 || p0 !== 43'sd25) begin failures++; $display("FAIL mid_rst_acc got %0d valid %b exp 25 valid 1", p0, po0); end
  endtask

  initial begin
    reset   = 1'b1;
    pipe_in = 1'b0;
    a       = '0;
    b       = '0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    test_reset();
    test_latency();
    test_extremes();
    test_accumulate();
    test_round_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mult_acc.md
Name: pipe_mult_acc

Overview:
Parametrised pipelined signed multiplier-accumulator for the fast processing datapath. It multiplies two signed inputs over a latency of STAGES clocks, and can optionally accumulate the products. The result is rounded and shifted, then saturated or wrapped to OUT_WIDTH. A pipeline enable bit travels alongside the data and drives the clock enable of every stage for power saving, so chained blocks sequence off pipe_out.

Parameters:
A_WIDTH, 25, width of signed input a
B_WIDTH, 18, width of signed input b
STAGES, 3, latency pipe_in -> pipe_out in clocks; legal 3..8
ACC_WIDTH, 48, accumulator width; must be >= A_WIDTH+B_WIDTH
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output, with round-half-up
OUT_WIDTH, 43, width of signed output p
SATURATE, 1, 1 = clamp on overflow, 0 = wrap (truncate MSBs)

Ports:
clk  in  1  fast processing clock
reset  in  1  synchronous, active-high reset
pipe_in  in  1  sample-valid / pipeline enable for a, b, acc_en, acc_clr
a  in  A_WIDTH  signed multiplicand, MSB-aligned
b  in  B_WIDTH  signed multiplier, MSB-aligned
acc_en  in  1  1 = add product to accumulator; 0 = result is the product alone
acc_clr  in  1  1 = discard previous accumulator before adding this product (start of sum)
pipe_out  out  1  result-valid, exactly STAGES clocks after pipe_in
p  out  OUT_WIDTH  signed result
ovf  out  1  result did not fit in OUT_WIDTH (qualified by pipe_out)

Behaviour:
- Interface fixed: one clock clk; reset is synchronous and active-high.
- Pipe chain: pipe[0] <= pipe_in; pipe[k] <= pipe[k-1]; pipe_out = pipe[STAGES-1]. One sample per clock accepted, no backpressure, bubbles allowed.
- Stage 0 (enabled by pipe_in): register a, b, acc_en, acc_clr.
- Stage 1 (enabled by pipe[0]): register the full product a*b, signed, A_WIDTH+B_WIDTH bits; control bits travel with it.
- Stages 2..STAGES-2 (enabled by pipe[k-1]): pure delay registers for product and control; none when STAGES=3.
- Final stage (enabled by pipe[STAGES-2]):
  - base = (acc_en && !acc_clr) ? acc : 0.
  - acc_next = base + sign-extended product, modulo 2^ACC_WIDTH (wraps, no flag).
  - acc <= acc_next.
  - r = (acc_next + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT, evaluated at ACC_WIDTH+1 bits.
  - ovf <= r outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - p <= SATURATE ? clamp(r) : r[OUT_WIDTH-1:0].
- Every stage holds its contents when its enable is low. p, ovf and acc are held between valid results, so the accumulator persists across bubbles.
- acc_clr with acc_en=0 is equivalent to acc_en=0.
- Reset: all pipe bits, data registers, acc, p and ovf are set to 0. Samples in flight when reset is asserted are discarded and never produce pipe_out. pipe_in is ignored during a reset cycle.
- Simultaneous pipe_in and a valid final stage is the normal streaming case; there is no interaction between them.

Test Plan:
- Reset: hold reset 2 clocks with pipe_in=1 and random a, b -> pipe_out=0, p=0, ovf=0 during reset and for 3 clocks after release.
- Latency and hold: defaults; a=-3, b=7, pipe_in pulse at clock 0, acc_en=0 -> pipe_out=1 only at clock 3, p=-21, ovf=0; p stays -21 through 10 idle clocks. Repeat with STAGES=5 -> pipe_out at clock 5.
- Extremes: a=-2^24, b=-2^17 -> p=2^41, ovf=0. a=2^24-1, b=-2^17 -> p=-(2^24-1)*2^17.
- Accumulate: 4 back-to-back samples a=1000, b=1000; first has acc_clr=1, acc_en=1, rest have acc_en=1 -> p=1e6, 2e6, 3e6, 4e6 at clocks 3..6. With a 2-clock bubble after the 2nd sample -> still 3e6, 4e6. A new acc_clr sample then yields its product alone.
- Round and saturate: OUT_WIDTH=16, OUT_SHIFT=4.
  - a=3, b=3 -> p=1.
  - a=-3, b=3 -> p=-1.
  - a=1000, b=1000 -> p=32767, ovf=1.
  - Same with SATURATE=0 -> p=-3036, ovf=1.
- Reset mid-operation: pipe_in at clocks 0 and 1, reset at clock 2 -> no pipe_out. Then a=5, b=5 with acc_en=1, acc_clr=0 -> p=25 (acc was cleared).
